// File: rtl/conv_accel_pkg.sv
// conv_accel_pkg: shared constants, precision-mode encodings and the FSM
// state type for the convolution core.
//   Width constants : SPAD_DATA_WIDTH, ADDR_WIDTH, DATA_WIDTH, SPAD_DEPTH,
//                     OUT_WIDTH (accumulator/output), NUM_LANES
//   Mode encodings  : P8, P4, P2 (2'b11 behaves as P8)
//   state_t         : IDLE, FETCH, DRAIN, EMIT, DONE
package conv_accel_pkg;

    localparam int SPAD_DATA_WIDTH = 64;
    localparam int ADDR_WIDTH      = 8;
    localparam int DATA_WIDTH      = 8;
    localparam int SPAD_DEPTH      = 256;
    localparam int OUT_WIDTH       = 2 * DATA_WIDTH;
    localparam int NUM_LANES       = SPAD_DATA_WIDTH / DATA_WIDTH;

    localparam logic [1:0] P8 = 2'b00;
    localparam logic [1:0] P4 = 2'b01;
    localparam logic [1:0] P2 = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_DRAIN = 3'd2,
        S_EMIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/conv_accel_lane_mac.sv
// lane_mac: combinational multiply-sum of two scratchpad words.
//   a_i, b_i     : SPAD_DATA_WIDTH operand words, lane n = bits [8n+7:8n]
//   mode_i       : precision mode (P8 / P4 / P2, 2'b11 = P8)
//   lane_mask_i  : one bit per lane; only set lanes contribute
//   sum_o        : signed OUT_WIDTH sum of all enabled lane products,
//                  wrapping modulo 2^OUT_WIDTH
module lane_mac
    import conv_accel_pkg::*;
(
    input  logic [SPAD_DATA_WIDTH-1:0] a_i,
    input  logic [SPAD_DATA_WIDTH-1:0] b_i,
    input  logic [1:0]                 mode_i,
    input  logic [NUM_LANES-1:0]       lane_mask_i,
    output logic [OUT_WIDTH-1:0]       sum_o
);

    // Product of one byte lane. Sub-fields are sign-extended to the full
    // output width before multiplying so every partial product is exact.
    function automatic logic [OUT_WIDTH-1:0] lane_prod(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [1:0]            mode
    );
        logic signed [OUT_WIDTH-1:0] p;
        p = '0;
        case (mode)
            P4: begin
                for (int h = 0; h < 2; h++) begin
                    p = p + $signed({{12{a[h*4+3]}}, a[h*4 +: 4]})
                          * $signed({{12{b[h*4+3]}}, b[h*4 +: 4]});
                end
            end
            P2: begin
                for (int q = 0; q < 4; q++) begin
                    p = p + $signed({{14{a[q*2+1]}}, a[q*2 +: 2]})
                          * $signed({{14{b[q*2+1]}}, b[q*2 +: 2]});
                end
            end
            default: begin
                p = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
            end
        endcase
        return p;
    endfunction

    always_comb begin
        sum_o = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            if (lane_mask_i[n]) begin
                sum_o = sum_o + lane_prod(a_i[n*DATA_WIDTH +: DATA_WIDTH],
                                          b_i[n*DATA_WIDTH +: DATA_WIDTH],
                                          mode_i);
            end
        end
    end

endmodule

// File: rtl/conv_accel_core.sv
// conv_accel_core: single-engine KxK convolution over a square ifmap,
// producing one output channel serially in raster order (ox fastest).
//   i_clk, i_rst, i_reg_clear : clock, async reset, synchronous soft clear
//   i_p_mode                  : lane precision mode
//   i_data_in, i_write_addr, i_spad_select, i_write_en : scratchpad writes
//   i_route_en                : start and hold a run; falling edge aborts
//   i_i_*, i_o_size, i_stride, i_w_*, i_route_size    : run geometry
//   o_ofmap, o_ofmap_valid    : output pixel and its one-cycle strobe
//   o_done                    : run complete, held until i_route_en falls
//   o_fsm_state               : current FSM state, for observation
//
// Handshake: the host holds i_route_en high for the whole run and the
// geometry inputs stable; each o_ofmap_valid pulse carries one pixel and
// cannot be back-pressured; o_done stays high until i_route_en drops.
module conv_accel_core
    import conv_accel_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_reg_clear,
    input  logic [1:0]                 i_p_mode,
    input  logic [SPAD_DATA_WIDTH-1:0] i_data_in,
    input  logic [ADDR_WIDTH-1:0]      i_write_addr,
    input  logic                       i_spad_select,
    input  logic                       i_write_en,
    input  logic                       i_route_en,
    input  logic [ADDR_WIDTH-1:0]      i_i_start_addr,
    input  logic [ADDR_WIDTH-1:0]      i_i_addr_end,
    input  logic [ADDR_WIDTH-1:0]      i_i_size,
    input  logic [ADDR_WIDTH-1:0]      i_o_size,
    input  logic [ADDR_WIDTH-1:0]      i_i_c_size,
    input  logic [ADDR_WIDTH-1:0]      i_i_c,
    input  logic [ADDR_WIDTH-1:0]      i_stride,
    input  logic [ADDR_WIDTH-1:0]      i_w_start_addr,
    input  logic [ADDR_WIDTH-1:0]      i_w_addr_offset,
    input  logic [ADDR_WIDTH-1:0]      i_route_size,
    output logic [OUT_WIDTH-1:0]       o_ofmap,
    output logic                       o_ofmap_valid,
    output logic                       o_done,
    output state_t                     o_fsm_state
);

    localparam int IA_W = 20;  // wide enough for any ifmap address expression

    logic [SPAD_DATA_WIDTH-1:0] weight_mem [SPAD_DEPTH];
    logic [SPAD_DATA_WIDTH-1:0] ifmap_mem  [SPAD_DEPTH];
    logic [SPAD_DATA_WIDTH-1:0] w_rdata_q, i_rdata_q;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] kx_q, kx_d, ky_q, ky_d;
    logic [ADDR_WIDTH-1:0] ox_q, ox_d, oy_q, oy_d;
    logic [OUT_WIDTH-1:0]  acc_q, acc_d;
    logic [OUT_WIDTH-1:0]  ofmap_q, ofmap_d;
    logic                  valid_q, valid_d;
    logic                  rd_valid_q, rd_valid_d;

    logic [ADDR_WIDTH-1:0] k_size, k_max, tap_idx, w_addr;
    logic [IA_W-1:0]       i_addr_full;
    logic                  i_oob;
    logic [NUM_LANES-1:0]  lane_mask;
    logic [ADDR_WIDTH:0]   lane_end;
    logic [OUT_WIDTH-1:0]  mac_sum;
    logic                  last_x, last_y;

    // Kernel edge from tap count: 1 -> 1, 4 -> 2, anything else -> 3.
    always_comb begin
        if (i_route_size == 8'd1)      k_size = 8'd1;
        else if (i_route_size == 8'd4) k_size = 8'd2;
        else                           k_size = 8'd3;
    end
    assign k_max   = k_size - 8'd1;
    assign tap_idx = ky_q * k_size + kx_q;
    assign w_addr  = i_w_start_addr + tap_idx * i_w_addr_offset;

    assign i_addr_full = IA_W'(i_i_start_addr)
                       + (IA_W'(oy_q) * IA_W'(i_stride) + IA_W'(ky_q)) * IA_W'(i_i_size)
                       + IA_W'(ox_q) * IA_W'(i_stride) + IA_W'(kx_q);
    assign i_oob = i_addr_full > IA_W'(i_i_addr_end);

    // Scratchpads: write port plus registered read port. A read of the
    // address being written sees the previous contents (NBA ordering).
    always_ff @(posedge i_clk) begin
        if (i_write_en) begin
            if (i_spad_select) ifmap_mem[i_write_addr]  <= i_data_in;
            else               weight_mem[i_write_addr] <= i_data_in;
        end
        w_rdata_q <= weight_mem[w_addr];
        i_rdata_q <= i_oob ? '0 : ifmap_mem[i_addr_full[ADDR_WIDTH-1:0]];
    end

    // Lanes i_i_c .. i_i_c+i_i_c_size-1; lanes past the word are dropped.
    assign lane_end = {1'b0, i_i_c} + {1'b0, i_i_c_size};
    always_comb begin
        lane_mask = '0;
        for (int n = 0; n < NUM_LANES; n++) begin
            lane_mask[n] = (9'(n) >= {1'b0, i_i_c}) && (9'(n) < lane_end);
        end
    end

    lane_mac u_lane_mac (
        .a_i         (i_rdata_q),
        .b_i         (w_rdata_q),
        .mode_i      (i_p_mode),
        .lane_mask_i (lane_mask),
        .sum_o       (mac_sum)
    );

    assign last_x = ({1'b0, ox_q} + 9'd1) >= {1'b0, i_o_size};
    assign last_y = ({1'b0, oy_q} + 9'd1) >= {1'b0, i_o_size};

    always_comb begin
        state_d    = state_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        // A pair read in the previous cycle is accumulated now.
        acc_d      = rd_valid_q ? (acc_q + mac_sum) : acc_q;
        ofmap_d    = ofmap_q;
        valid_d    = 1'b0;
        rd_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_route_en) begin
                    state_d = S_FETCH;
                    acc_d   = '0;
                    kx_d    = '0;
                    ky_d    = '0;
                    ox_d    = '0;
                    oy_d    = '0;
                end
            end
            S_FETCH: begin
                rd_valid_d = 1'b1;
                if (kx_q == k_max) begin
                    kx_d = '0;
                    if (ky_q == k_max) begin
                        ky_d    = '0;
                        state_d = S_DRAIN;
                    end else begin
                        ky_d = ky_q + 8'd1;
                    end
                end else begin
                    kx_d = kx_q + 8'd1;
                end
            end
            S_DRAIN: state_d = S_EMIT;
            S_EMIT: begin
                ofmap_d = acc_q;
                valid_d = 1'b1;
                acc_d   = '0;
                if (last_x) begin
                    ox_d = '0;
                    if (last_y) begin
                        state_d = S_DONE;
                    end else begin
                        oy_d    = oy_q + 8'd1;
                        state_d = S_FETCH;
                    end
                end else begin
                    ox_d    = ox_q + 8'd1;
                    state_d = S_FETCH;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        // Dropping i_route_en abandons the run without another strobe.
        if ((state_q != S_IDLE) && !i_route_en) begin
            state_d    = S_IDLE;
            valid_d    = 1'b0;
            rd_valid_d = 1'b0;
            ofmap_d    = ofmap_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            acc_q      <= '0;
            ofmap_q    <= '0;
            valid_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else if (i_reg_clear) begin
            state_q    <= S_IDLE;
            kx_q       <= '0;
            ky_q       <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            acc_q      <= '0;
            ofmap_q    <= '0;
            valid_q    <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            acc_q      <= acc_d;
            ofmap_q    <= ofmap_d;
            valid_q    <= valid_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_ofmap       = ofmap_q;
    assign o_ofmap_valid = valid_q;
    assign o_done        = (state_q == S_DONE);
    assign o_fsm_state   = state_q;

endmodule

// File: tb/tb_conv_accel_core.sv
module tb_conv_accel_core;
    import conv_accel_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_clear;
    logic [1:0]  p_mode;
    logic [63:0] data_in;
    logic [7:0]  write_addr;
    logic        spad_select;
    logic        write_en;
    logic        route_en;
    logic [7:0]  i_start, i_end, i_size, o_size, c_size, c_first;
    logic [7:0]  stride, w_start, w_off, route_size;
    logic [15:0] ofmap;
    logic        ofmap_valid;
    logic        done;
    state_t      fsm_state;

    logic [63:0] tb_w [256];
    logic [63:0] tb_i [256];
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int          cyc_q [$];
    int          cyc = 0;
    int          tests_run = 0;
    int          fails = 0;

    conv_accel_core dut (
        .i_clk           (clk),
        .i_rst           (rst),
        .i_reg_clear     (reg_clear),
        .i_p_mode        (p_mode),
        .i_data_in       (data_in),
        .i_write_addr    (write_addr),
        .i_spad_select   (spad_select),
        .i_write_en      (write_en),
        .i_route_en      (route_en),
        .i_i_start_addr  (i_start),
        .i_i_addr_end    (i_end),
        .i_i_size        (i_size),
        .i_o_size        (o_size),
        .i_i_c_size      (c_size),
        .i_i_c           (c_first),
        .i_stride        (stride),
        .i_w_start_addr  (w_start),
        .i_w_addr_offset (w_off),
        .i_route_size    (route_size),
        .o_ofmap         (ofmap),
        .o_ofmap_valid   (ofmap_valid),
        .o_done          (done),
        .o_fsm_state     (fsm_state)
    );

    // Clock / cycle counter / output monitor
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (ofmap_valid) begin
            got_q.push_back(ofmap);
            cyc_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain arithmetic over the convolution definition.
    function automatic int sval(input int x, input int bits);
        return (x >= (1 << (bits - 1))) ? x - (1 << bits) : x;
    endfunction

    function automatic int lane_val(input logic [7:0] a, input logic [7:0] b, input logic [1:0] mode);
        int av = int'(a);
        int bv = int'(b);
        int r = 0;
        if (mode == 2'b01) begin
            for (int h = 0; h < 2; h++)
                r += sval((av >> (4 * h)) & 15, 4) * sval((bv >> (4 * h)) & 15, 4);
        end else if (mode == 2'b10) begin
            for (int q = 0; q < 4; q++)
                r += sval((av >> (2 * q)) & 3, 2) * sval((bv >> (2 * q)) & 3, 2);
        end else begin
            r = sval(av, 8) * sval(bv, 8);
        end
        return r;
    endfunction

    function automatic int kernel_k();
        return (route_size == 8'd1) ? 1 : ((route_size == 8'd4) ? 2 : 3);
    endfunction

    task automatic build_expected();
        int k = kernel_k();
        exp_q.delete();
        for (int oy = 0; oy < int'(o_size); oy++) begin
            for (int ox = 0; ox < int'(o_size); ox++) begin
                int acc = 0;
                for (int t = 0; t < k * k; t++) begin
                    int ky = t / k;
                    int kx = t % k;
                    int ia = int'(i_start) + (oy * int'(stride) + ky) * int'(i_size)
                           + ox * int'(stride) + kx;
                    int wa = (int'(w_start) + t * int'(w_off)) % 256;
                    logic [63:0] iw = (ia > int'(i_end)) ? 64'h0 : tb_i[ia % 256];
                    logic [63:0] ww = tb_w[wa];
                    for (int ln = int'(c_first); ln < int'(c_first) + int'(c_size); ln++) begin
                        if (ln < 8) acc += lane_val(iw[ln*8 +: 8], ww[ln*8 +: 8], p_mode);
                    end
                end
                exp_q.push_back(16'(acc));
            end
        end
    endtask

    // Driver tasks
    task automatic write_word(input logic sel, input logic [7:0] addr, input logic [63:0] d);
        write_en    = 1'b1;
        spad_select = sel;
        write_addr  = addr;
        data_in     = d;
        if (sel) tb_i[addr] = d;
        else     tb_w[addr] = d;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    // rnd = 1: random words; otherwise every word is pattern.
    task automatic fill(input logic sel, input bit rnd, input logic [63:0] pattern);
        for (int a = 0; a < 256; a++)
            write_word(sel, 8'(a), rnd ? {$urandom, $urandom} : pattern);
    endtask

    task automatic set_geom(input int isz, input int osz, input int st, input int rs,
                            input int cs, input int cf, input logic [1:0] md);
        i_size = 8'(isz); o_size = 8'(osz); stride = 8'(st); route_size = 8'(rs);
        c_size = 8'(cs); c_first = 8'(cf); p_mode = md;
        i_start = 8'd0; i_end = 8'd255; w_start = 8'd0; w_off = 8'd1;
    endtask

    // One full run: compares values, strobe timing and completion.
    task automatic run_job(input string tag);
        int kk = kernel_k() * kernel_k();
        int c0;
        build_expected();
        got_q.delete();
        cyc_q.delete();
        @(negedge clk);
        c0 = cyc;
        route_en = 1'b1;
        for (int i = 0; i < 3000 && !done; i++) @(negedge clk);
        @(negedge clk);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_px%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
            if (i == 0) check({tag, "_lat"}, 32'(cyc_q[0]), 32'(c0 + 1 + kk + 2));
            else check($sformatf("%s_gap%0d", tag, i), 32'(cyc_q[i] - cyc_q[i-1]), 32'(kk + 2));
        end
        route_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_done_drop"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; reg_clear = 1'b0; route_en = 1'b0; write_en = 1'b0;
        spad_select = 1'b0; write_addr = '0; data_in = '0;
        set_geom(4, 2, 1, 9, 1, 0, 2'b00);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ofmap", 32'(ofmap), 32'd0);
        check("rst_valid", 32'(ofmap_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_state", 32'(fsm_state), 32'(S_IDLE));

        // Basic 8-bit: ones in lane 0, 3x3 kernel, 9 per pixel.
        fill(1'b1, 1'b0, 64'h01);
        fill(1'b0, 1'b0, 64'h01);
        set_geom(4, 2, 1, 9, 1, 0, 2'b00);
        run_job("basic");
        check("basic_const", 32'(got_q[0]), 32'h0009);

        // Stride 2, signed: -1 * 2 over 9 taps.
        fill(1'b1, 1'b0, 64'hFF);
        fill(1'b0, 1'b0, 64'h02);
        set_geom(5, 2, 2, 9, 1, 0, 2'b00);
        run_job("stride");
        check("stride_const", 32'(got_q[3]), 32'hFFEE);

        // Two channels starting at lane 1; lane 0 must be excluded.
        fill(1'b1, 1'b0, 64'h0001_017F);
        fill(1'b0, 1'b0, 64'h0001_017F);
        set_geom(4, 2, 1, 9, 2, 1, 2'b00);
        run_job("chan");
        check("chan_const", 32'(got_q[0]), 32'h0012);

        // 4-bit and 2-bit precision.
        fill(1'b1, 1'b0, {8{8'h11}});
        fill(1'b0, 1'b0, {8{8'h11}});
        set_geom(4, 2, 1, 9, 1, 0, 2'b01);
        run_job("p4");
        check("p4_const", 32'(got_q[1]), 32'h0012);
        fill(1'b1, 1'b0, {8{8'h55}});
        fill(1'b0, 1'b0, {8{8'h55}});
        set_geom(4, 2, 1, 9, 1, 0, 2'b10);
        run_job("p2");
        check("p2_const", 32'(got_q[2]), 32'h0024);

        // Bounds: everything past address 11 reads as zero.
        fill(1'b1, 1'b0, 64'h01);
        fill(1'b0, 1'b0, 64'h01);
        set_geom(4, 2, 1, 9, 1, 0, 2'b00);
        i_end = 8'd11;
        run_job("bounds");
        check("bounds_top", 32'(got_q[0]), 32'd9);
        check("bounds_bot", 32'(got_q[3]), 32'd6);

        // Randomised geometry, precision, lanes and data.
        fill(1'b1, 1'b1, 64'h0);
        fill(1'b0, 1'b1, 64'h0);
        for (int it = 0; it < 8; it++) begin
            int rs, k, st, os;
            rs = (it % 3 == 0) ? 1 : ((it % 3 == 1) ? 4 : 9);
            k  = (rs == 1) ? 1 : ((rs == 4) ? 2 : 3);
            st = $urandom_range(1, 2);
            os = $urandom_range(1, 3);
            set_geom((os - 1) * st + k + $urandom_range(0, 2), os, st, rs,
                     $urandom_range(0, 8), $urandom_range(0, 7), 2'($urandom_range(0, 3)));
            i_start = 8'($urandom_range(0, 60));
            i_end   = ($urandom_range(0, 1) == 1) ? 8'd255 : 8'($urandom_range(20, 255));
            w_start = 8'($urandom_range(0, 255));
            w_off   = 8'($urandom_range(0, 5));
            run_job($sformatf("rand%0d", it));
        end

        // Soft clear after the 2nd strobe, with route dropped.
        fill(1'b1, 1'b0, 64'h01);
        fill(1'b0, 1'b0, 64'h01);
        set_geom(4, 2, 1, 9, 1, 0, 2'b00);
        got_q.delete();
        @(negedge clk);
        route_en = 1'b1;
        for (int i = 0; i < 200 && got_q.size() < 2; i++) @(negedge clk);
        check("clr_two_strobes", 32'(got_q.size()), 32'd2);
        reg_clear = 1'b1;
        route_en  = 1'b0;
        @(negedge clk);
        reg_clear = 1'b0;
        check("clr_ofmap", 32'(ofmap), 32'd0);
        repeat (40) @(negedge clk);
        check("clr_no_strobe", 32'(got_q.size()), 32'd2);
        check("clr_done", 32'(done), 32'd0);
        check("clr_state", 32'(fsm_state), 32'(S_IDLE));
        run_job("rerun");

        // Abort by dropping route after the first strobe.
        got_q.delete();
        route_en = 1'b1;
        for (int i = 0; i < 200 && got_q.size() < 1; i++) @(negedge clk);
        route_en = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_strobes", 32'(got_q.size()), 32'd1);
        check("abort_state", 32'(fsm_state), 32'(S_IDLE));

        // Async reset in the middle of FETCH, seen before the next edge.
        run_job("pre_rst");
        @(negedge clk);
        route_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_fetch", 32'(fsm_state), 32'(S_FETCH));
        #2 rst = 1'b1;
        #1;
        check("arst_ofmap", 32'(ofmap), 32'd0);
        check("arst_valid", 32'(ofmap_valid), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_state", 32'(fsm_state), 32'(S_IDLE));
        route_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_job("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/conv_accel_core.md
Name: conv_accel_core

Overview:
- Single-engine CNN convolution core.
- Holds two write-loaded scratchpads: weights and ifmap.
- On i_route_en, streams one output channel of a KxK convolution over a square ifmap, serially, in raster order.
- Sits below the host/loader. The host fills the scratchpads, programs the geometry inputs, then waits for o_done.

Parameters:
- SPAD_DATA_WIDTH, 64, scratchpad word width. Holds 8 byte lanes; lane n is channel n.
- ADDR_WIDTH, 8, width of all address and size inputs.
- DATA_WIDTH, 8, lane width. The output is 2*DATA_WIDTH.
- SPAD_DEPTH, 256, words per scratchpad.

Ports:
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_reg_clear  in  1  synchronous soft clear.
- i_p_mode  in  2  precision mode: 00 = 8-bit, 01 = 4-bit, 10 = 2-bit, 11 = same as 00.
- i_data_in  in  SPAD_DATA_WIDTH  write data.
- i_write_addr  in  ADDR_WIDTH  write address.
- i_spad_select  in  1  0 = weight scratchpad, 1 = ifmap scratchpad.
- i_write_en  in  1  write strobe.
- i_route_en  in  1  start and hold computation.
- i_i_start_addr, i_i_addr_end  in  ADDR_WIDTH  ifmap base address and last valid address.
- i_i_size, i_o_size  in  ADDR_WIDTH  ifmap width (= height) and output width (= height).
- i_i_c_size, i_i_c  in  ADDR_WIDTH  number of channels summed, and first lane.
- i_stride  in  ADDR_WIDTH  convolution stride, at least 1.
- i_w_start_addr, i_w_addr_offset  in  ADDR_WIDTH  weight base address and per-tap address step.
- i_route_size  in  ADDR_WIDTH  number of taps K*K, one of 1, 4 or 9.
- o_ofmap  out  2*DATA_WIDTH  output pixel, signed.
- o_ofmap_valid  out  1  one-cycle strobe per output pixel.
- o_done  out  1  all outputs have been emitted.

Behaviour:
- Reset (i_rst high, asynchronous):
  - FSM goes to IDLE.
  - Accumulator and counters go to 0.
  - o_ofmap = 0, o_ofmap_valid = 0, o_done = 0.
  - Scratchpad contents are not reset.
- i_reg_clear has the same effect as reset, but synchronous. It wins over every other event in the same cycle.
- Writes: when i_write_en is high, i_data_in goes to the scratchpad chosen by i_spad_select at i_write_addr on the clock edge.
  - Writes are accepted in any state.
  - A read of the same address in the same cycle returns the old data.
- Reads are synchronous, with 1-cycle latency.
- K is derived from i_route_size: 1 gives K = 1, 4 gives K = 2, anything else gives K = 3.
- Tap t runs over 0..K*K-1, with ky = t/K and kx = t%K.
  - Weight address = i_w_start_addr + t*i_w_addr_offset.
  - Ifmap address = i_i_start_addr + (oy*i_stride+ky)*i_i_size + ox*i_stride+kx.
  - If the ifmap address is greater than i_i_addr_end, the ifmap word reads as 0.
- Lane MAC: lanes i_i_c .. i_i_c+i_i_c_size-1 are summed. Lane indices of 8 or more are ignored. Per lane, by mode:
  - 00: one signed 8x8 product.
  - 01: two signed 4-bit sub-products (bits [7:4] and [3:0]), summed.
  - 10: four signed 2-bit sub-products, summed.
- The accumulator is 2*DATA_WIDTH bits and wraps modulo 2^16.
- FSM states:
  - IDLE: when i_route_en is high and o_done is 0, clear the accumulator, set oy = ox = t = 0, go to FETCH.
  - FETCH: issue the tap-t reads every cycle for K*K cycles. Each returned pair is accumulated one cycle later. Then go to DRAIN.
  - DRAIN: accumulate the last tap. Go to EMIT.
  - EMIT: o_ofmap = accumulator, o_ofmap_valid = 1 for this cycle only. Advance ox, then oy. If this was the last pixel, go to DONE. Otherwise clear the accumulator and go to FETCH.
  - DONE: o_done = 1 and is held. The FSM returns to IDLE only when i_route_en falls or a clear occurs.
- Per-pixel period is K*K+2 cycles. The first o_ofmap_valid comes K*K+2 cycles after the IDLE→FETCH edge.
- Output order is raster: ox fastest.
- i_route_en falling mid-run aborts to IDLE with no further strobes.
- Geometry inputs must be held stable while routing.

Decomposition:
- Package conv_accel_pkg holds:
  - width constants;
  - the p_mode encodings (P8, P4, P2);
  - the FSM state enum.
- Sub-module lane_mac: a combinational SPAD_DATA_WIDTH x SPAD_DATA_WIDTH multiply-sum with mode, lane mask and signed 16-bit result.
- The two scratchpads are plain arrays inside the core.

Test Plan:
- Basic 8-bit: i_i_size 4, i_o_size 2, stride 1, c_size 1, c 0, route 9. Every ifmap and weight word = 0x01 in lane 0. Expect 4 valid strobes of 0x0009 at an 11-cycle spacing, then o_done.
- Stride and signed: i_i_size 5, i_o_size 2, stride 2. Ifmap lane 0 = 0xFF (-1), weight lane 0 = 0x02. Expect 4 outputs of 0xFFEE (-18).
- Channels and lane offset: c_size 2, c 1. Lanes 1 and 2 = 0x01 in both ifmap and weights; lane 0 = 0x7F. Expect 0x0012 on every output.
- Precision: mode 01 with all bytes 0x11 and c_size 1 gives 0x0012. Mode 10 with 0x55 x 0x55 gives 4 per tap, so 0x0024.
- Bounds: i_i_addr_end set to the address of input row 2. Pixels reaching beyond it lose those taps; e.g. with all-ones data and i_i_size 4, i_o_size 2, end at address 11, bottom-row outputs = 6.
- Clear and reset: assert i_reg_clear after the 2nd strobe. Expect no strobes, o_done 0, FSM IDLE, while scratchpad data is retained. A second run (i_route_en low then high) reproduces the full output. Asserting i_rst mid-FETCH zeroes all outputs immediately.
